// File: rtl/fw_status_pkg.sv
// Shared register map, response codes and write-request type for the
// firmware status AXI4-Lite responder.
package fw_status_pkg;

    localparam int N_REGS = 8;

    localparam logic [2:0] REG_VERSION   = 3'd0;
    localparam logic [2:0] REG_SCRATCH   = 3'd1;
    localparam logic [2:0] REG_CONTROL   = 3'd2;
    localparam logic [2:0] REG_STATUS    = 3'd3;
    localparam logic [2:0] REG_EVENT     = 3'd4;
    localparam logic [2:0] REG_UPTIME_LO = 3'd5;
    localparam logic [2:0] REG_UPTIME_HI = 3'd6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [2:0]  idx;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_req_t;

    // Expand byte strobes into a per-bit enable mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{strb[i]}};
        return m;
    endfunction

endpackage

// File: rtl/fw_uptime_counter.sv
// Free-running 64-bit uptime counter; the high word is captured into a
// shadow when the low word is read so the pair reads coherently.
module fw_uptime_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snapshot,
    output logic [31:0] lo,
    output logic [31:0] shadow_hi
);

    logic [63:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            shadow_hi <= '0;
        end else begin
            cnt <= cnt + 64'd1;
            if (snapshot) shadow_hi <= cnt[63:32];
        end
    end

    assign lo = cnt[31:0];

endmodule

// File: rtl/fw_status_axil_slave.sv
// AXI4-Lite responder exposing version, scratch, control, status, sticky
// events and a coherent 64-bit uptime. One write and one read in flight.
module fw_status_axil_slave
    import fw_status_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] FW_VERSION         = 32'h0001_0000,
    parameter int          N_EVENTS           = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [31:0]                     status_i,
    input  logic [N_EVENTS-1:0]             event_i,
    output logic [31:0]                     ctrl_o
);

    localparam int IDX_W = $clog2(N_REGS);

    logic [IDX_W-1:0]    aw_idx_q;
    logic                aw_cap, w_cap, rst_done;
    logic [31:0]         w_data_q;
    logic [3:0]          w_strb_q;
    logic                aw_hs, w_hs, ar_hs, wr_fire;
    wr_req_t             wr;
    logic [31:0]         wmask, clr_full, ev_rd;
    logic [N_EVENTS-1:0] ev_q, ev_clr;
    logic [31:0]         scratch_q, control_q, status_q;
    logic [31:0]         up_lo, up_hi;
    logic [31:0]         rd_data;
    logic [1:0]          rd_resp;
    logic [IDX_W-1:0]    ar_idx;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // rst_done keeps READY low while reset is held, rising one cycle after release.
    assign S_AXI_AWREADY = rst_done && !aw_cap && !S_AXI_BVALID;
    assign S_AXI_WREADY  = rst_done && !w_cap && !S_AXI_BVALID;
    assign S_AXI_ARREADY = rst_done && !S_AXI_RVALID;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign ar_idx = S_AXI_ARADDR[IDX_W+1:2];

    // Merge captured halves with any handshake completing this cycle.
    assign wr_fire  = (aw_cap || aw_hs) && (w_cap || w_hs);
    assign wr.idx   = aw_cap ? aw_idx_q : S_AXI_AWADDR[IDX_W+1:2];
    assign wr.data  = w_cap ? w_data_q : S_AXI_WDATA;
    assign wr.strb  = w_cap ? w_strb_q : S_AXI_WSTRB;
    assign wmask    = strb_mask(wr.strb);
    assign clr_full = (wr_fire && wr.idx == REG_EVENT) ? (wr.data & wmask) : '0;
    assign ev_clr   = clr_full[N_EVENTS-1:0];
    assign ctrl_o   = control_q;

    fw_uptime_counter u_uptime (
        .clk       (S_AXI_ACLK),
        .rst_n     (S_AXI_ARESETN),
        .snapshot  (ar_hs && ar_idx == REG_UPTIME_LO),
        .lo        (up_lo),
        .shadow_hi (up_hi)
    );

    always_comb begin
        ev_rd = '0;
        ev_rd[N_EVENTS-1:0] = ev_q;
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (ar_idx)
            REG_VERSION:   rd_data = FW_VERSION;
            REG_SCRATCH:   rd_data = scratch_q;
            REG_CONTROL:   rd_data = control_q;
            REG_STATUS:    rd_data = status_q;
            REG_EVENT:     rd_data = ev_rd;
            REG_UPTIME_LO: rd_data = up_lo;
            REG_UPTIME_HI: rd_data = up_hi;
            default:       rd_resp = RESP_SLVERR;
        endcase
    end

    // Register file; set of an event wins over a same-cycle clear.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            scratch_q <= '0;
            control_q <= '0;
            status_q  <= '0;
            ev_q      <= '0;
        end else begin
            status_q <= status_i;
            ev_q     <= (ev_q & ~ev_clr) | event_i;
            if (wr_fire) begin
                case (wr.idx)
                    REG_SCRATCH: scratch_q <= (scratch_q & ~wmask) | (wr.data & wmask);
                    REG_CONTROL: control_q <= (control_q & ~wmask) | (wr.data & wmask);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rst_done     <= 1'b0;
            aw_cap       <= 1'b0;
            aw_idx_q     <= '0;
            w_cap        <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
        end else begin
            rst_done <= 1'b1;
            if (wr_fire) begin
                aw_cap       <= 1'b0;
                w_cap        <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= (wr.idx > REG_UPTIME_HI) ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (aw_hs) begin
                    aw_cap   <= 1'b1;
                    aw_idx_q <= S_AXI_AWADDR[IDX_W+1:2];
                end
                if (w_hs) begin
                    w_cap    <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
                if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
        end else if (ar_hs) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_data;
            S_AXI_RRESP  <= rd_resp;
        end else if (S_AXI_RVALID && S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fw_status_axil_slave.sv
// Scoreboard bench for fw_status_axil_slave: expected R/B responses are
// queued when a transfer is issued and compared when the DUT answers.
module tb_fw_status_axil_slave;
    import fw_status_pkg::*;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [4:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, ctrl_o;
    logic [31:0] status_i = '0;
    logic [15:0] event_i = '0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [33:0] r_exp_q[$];
    logic [1:0]  b_exp_q[$];
    logic [31:0] ctrl_b;

    always #5 clk = ~clk;

    fw_status_axil_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .status_i(status_i), .event_i(event_i), .ctrl_o(ctrl_o)
    );

    task automatic do_read(input logic [4:0] a, input string name);
        int t = 0;
        logic [33:0] exp;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        arvalid = 1'b0;
        while (!rvalid && t < 50) begin @(negedge clk); t++; end
        exp = (r_exp_q.size() != 0) ? r_exp_q.pop_front() : 34'bx;
        n_checks++;
        if (!rvalid) begin
            n_fail++;
            $display("FAIL %s: no RVALID within bound, required data=%h resp=%b", name, exp[33:2], exp[1:0]);
        end else begin
            if ({rdata, rresp} !== exp) begin
                n_fail++;
                $display("FAIL %s: got data=%h resp=%b, required data=%h resp=%b",
                         name, rdata, rresp, exp[33:2], exp[1:0]);
            end
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input logic [15:0] ev, input bit accept,
                            input string name, output logic [31:0] ctrl_at_b);
        int t = 0;
        bit aw_done = 0, w_done = 0, aw_go, w_go;
        logic [1:0] exp;
        ctrl_at_b = 'x;
        @(negedge clk);
        wdata = d; wstrb = s; wvalid = 1'b1; awaddr = a;
        while (!(aw_done && w_done) && t < 50) begin
            if (t >= aw_dly && !aw_done) awvalid = 1'b1;
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            if ((aw_done || aw_go) && (w_done || w_go)) event_i = ev;
            @(negedge clk);
            event_i = '0;
            if (aw_go) begin awvalid = 1'b0; aw_done = 1; end
            if (w_go)  begin wvalid = 1'b0;  w_done = 1;  end
            t++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && t < 60) begin @(negedge clk); t++; end
        exp = (b_exp_q.size() != 0) ? b_exp_q.pop_front() : 2'bxx;
        n_checks++;
        if (!bvalid) begin
            n_fail++;
            $display("FAIL %s: no BVALID within bound, required bresp=%b", name, exp);
        end else begin
            if (bresp !== exp) begin
                n_fail++;
                $display("FAIL %s: got bresp=%b, required %b", name, bresp, exp);
            end
            ctrl_at_b = ctrl_o;
            if (accept) begin
                bready = 1'b1;
                @(negedge clk);
                bready = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, ctrl_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b%b%b bv=%b rv=%b rdata=%h ctrl=%h, required all 0",
                     awready, wready, arready, bvalid, rvalid, rdata, ctrl_o);
        end
        aresetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b%b%b, required 111", awready, wready, arready);
        end
    endtask

    task automatic test_strobe();
        b_exp_q.push_back(RESP_OKAY);
        do_write(5'h04, 32'hDEAD_BEEF, 4'b0101, 0, '0, 1, "scratch_wr", ctrl_b);
        r_exp_q.push_back({32'h00AD_00EF, RESP_OKAY});
        do_read(5'h04, "scratch_strb");
    endtask

    task automatic test_w_before_aw();
        b_exp_q.push_back(RESP_OKAY);
        do_write(5'h08, 32'h1234_5678, 4'hF, 1, '0, 1, "ctrl_wr", ctrl_b);
        n_checks++;
        if (ctrl_b !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL ctrl_at_bvalid: got %h, required 12345678", ctrl_b);
        end
        r_exp_q.push_back({32'h1234_5678, RESP_OKAY});
        do_read(5'h0A, "ctrl_rd_low_addr_bits");
    endtask

    task automatic test_events();
        @(negedge clk); event_i = 16'h0009;
        @(negedge clk); event_i = '0;
        r_exp_q.push_back({32'h9, RESP_OKAY});
        do_read(5'h10, "event_capture");
        b_exp_q.push_back(RESP_OKAY);
        do_write(5'h10, 32'h1, 4'hF, 0, 16'h0001, 1, "event_clr_vs_set", ctrl_b);
        r_exp_q.push_back({32'h9, RESP_OKAY});
        do_read(5'h10, "event_set_wins");
        b_exp_q.push_back(RESP_OKAY);
        do_write(5'h10, 32'h8, 4'hF, 0, '0, 1, "event_clr3", ctrl_b);
        r_exp_q.push_back({32'h1, RESP_OKAY});
        do_read(5'h10, "event_w1c");
    endtask

    task automatic test_uptime();
        @(posedge clk);
        #1 force dut.u_uptime.cnt = 64'h0000_0000_FFFF_FFFE;
        #1 release dut.u_uptime.cnt;
        r_exp_q.push_back({32'hFFFF_FFFE, RESP_OKAY});
        do_read(5'h14, "uptime_lo");
        repeat (2) @(negedge clk);
        r_exp_q.push_back({32'h0, RESP_OKAY});
        do_read(5'h18, "uptime_hi_shadow");
    endtask

    task automatic test_unmapped();
        r_exp_q.push_back({32'h0, RESP_SLVERR});
        do_read(5'h1C, "unmapped_rd");
        b_exp_q.push_back(RESP_SLVERR);
        do_write(5'h1C, 32'hFFFF_FFFF, 4'hF, 0, '0, 0, "unmapped_wr", ctrl_b);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bvalid, bresp, awready, wready} !== {1'b1, RESP_SLVERR, 2'b00}) begin
                n_fail++;
                $display("FAIL b_hold cyc%0d: got bv=%b bresp=%b awr=%b wr=%b, required 1 10 0 0",
                         i, bvalid, bresp, awready, wready);
            end
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        n_checks++;
        if ({bvalid, awready, wready, ctrl_o} !== {3'b011, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL after_b: got bv=%b awr=%b wr=%b ctrl=%h, required 0 1 1 12345678",
                     bvalid, awready, wready, ctrl_o);
        end
        r_exp_q.push_back({32'h00AD_00EF, RESP_OKAY});
        do_read(5'h04, "scratch_untouched");
    endtask

    task automatic test_ro_regs();
        b_exp_q.push_back(RESP_OKAY);
        do_write(5'h00, 32'hFFFF_FFFF, 4'hF, 0, '0, 1, "version_wr", ctrl_b);
        r_exp_q.push_back({32'h0001_0000, RESP_OKAY});
        do_read(5'h00, "version_rd");
        status_i = 32'hA5A5_5A5A;
        repeat (2) @(negedge clk);
        r_exp_q.push_back({32'hA5A5_5A5A, RESP_OKAY});
        do_read(5'h0C, "status_rd");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        araddr = 5'h04; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        n_checks++;
        if (rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_r: got rvalid=%b, required 1", rvalid);
        end
        aresetn = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rvalid, ctrl_o} !== 33'h0) begin
            n_fail++;
            $display("FAIL reset_abort: got rvalid=%b ctrl=%h, required 0 0", rvalid, ctrl_o);
        end
        aresetn = 1'b1;
        @(negedge clk);
        r_exp_q.push_back({32'h0, RESP_OKAY});
        do_read(5'h04, "scratch_after_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_strobe();
        test_w_before_aw();
        test_events();
        test_uptime();
        test_unmapped();
        test_ro_regs();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
